usb_rx_crc_ctrl: RTL and testbench

//  Sequences the serial CRC-16 checker for the USB receiver.
//  - Watches the decoded, unstuffed bit stream and captures the 8-bit PID.
//  - For DATA packets only, feeds payload+CRC bits to the checker and judges the residual at EOP.
//  - Reports per-packet CRC, length and PID status to the RX control FSM.

---
 rtl/usb_rx_crc_ctrl_if.sv | 34 +++
 rtl/usb_rx_crc_ctrl.sv | 151 +++++++++++++++
 tb/tb_usb_rx_crc_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_crc_ctrl_if.sv
// Bundle between the USB RX CRC sequencer, the receiver front end, the serial
// CRC-16 checker and the RX control FSM.
//   master : the sequencer (consumes bit stream + crc_pass, drives checker/status)
//   slave  : the environment (drives bit stream + crc_pass, consumes the rest)
interface usb_rx_crc_ctrl_if;
  // decoded bit stream from the receiver
  logic rcving;
  logic shift_enable;
  logic d_orig;
  logic eop;
  // serial CRC-16 checker
  logic crc_pass;
  logic crc_clear;
  logic crc_shift_en;
  logic crc_serial_in;
  // per-packet status to the RX control FSM
  logic pkt_done;
  logic pkt_is_data;
  logic crc_err;
  logic len_err;
  logic pid_err;

  modport master (
    input  rcving, shift_enable, d_orig, eop, crc_pass,
    output crc_clear, crc_shift_en, crc_serial_in,
    output pkt_done, pkt_is_data, crc_err, len_err, pid_err
  );

  modport slave (
    output rcving, shift_enable, d_orig, eop, crc_pass,
    input  crc_clear, crc_shift_en, crc_serial_in,
    input  pkt_done, pkt_is_data, crc_err, len_err, pid_err
  );
endinterface

// File: rtl/usb_rx_crc_ctrl.sv
// Sequences the serial CRC-16 checker for the USB receiver: captures the PID,
// feeds DATA payload+CRC bits to the checker and judges the residual at EOP,
// then reports CRC/length/PID status for the packet.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   bus          usb_rx_crc_ctrl_if.master (bit stream in, checker control out,
//                per-packet status out)
// Optional feature (macro RX_CRC_ERRCNT_EN):
//   errcnt_clr   in   synchronous clear of the error counter
//   crc_err_cnt  out  saturating count of DATA packets with a CRC error
module usb_rx_crc_ctrl #(
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic clk,
  input  logic n_rst,
  usb_rx_crc_ctrl_if.master bus
`ifdef RX_CRC_ERRCNT_EN
  ,
  input  logic       errcnt_clr,
  output logic [7:0] crc_err_cnt
`endif
);

  localparam int unsigned SAT_BITS = (MAX_PAYLOAD + 3) * 8;
  localparam int unsigned MAX_BITS = (MAX_PAYLOAD + 2) * 8;
  localparam int unsigned MIN_BITS = 16;
  localparam int unsigned CNT_W    = $clog2(SAT_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_SKIP,
    S_FLUSH,
    S_EVAL
  } state_t;

  state_t           state;
  logic [7:0]       pid;
  logic [2:0]       pid_cnt;
  logic             pid_full;
  logic [CNT_W-1:0] bit_cnt;

  logic [7:0] pid_next;
  logic       abort;
  logic       data_pkt;
  logic       len_bad;
  logic       pid_bad;

  // Packet classification from the captured PID and bit count
  always_comb begin
    pid_next = {bus.d_orig, pid[7:1]};
    abort    = !bus.rcving && !bus.eop;
    data_pkt = pid_full && (pid[1:0] == 2'b11);
    len_bad  = (bit_cnt[2:0] != 3'd0) ||
               (bit_cnt < CNT_W'(MIN_BITS)) ||
               (bit_cnt > CNT_W'(MAX_BITS));
    pid_bad  = !pid_full || (pid[7:4] != ~pid[3:0]);
  end

  // Checker stays preset until payload bits start flowing
  assign bus.crc_clear = (state == S_IDLE) || (state == S_PID);

  // Sequencer FSM with registered checker strobes and status
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= S_IDLE;
      pid               <= '0;
      pid_cnt           <= '0;
      pid_full          <= 1'b0;
      bit_cnt           <= '0;
      bus.crc_shift_en  <= 1'b0;
      bus.crc_serial_in <= 1'b0;
      bus.pkt_done      <= 1'b0;
      bus.pkt_is_data   <= 1'b0;
      bus.crc_err       <= 1'b0;
      bus.len_err       <= 1'b0;
      bus.pid_err       <= 1'b0;
    end else begin
      bus.pkt_done     <= 1'b0;
      bus.crc_shift_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.rcving) begin
            state           <= S_PID;
            pid_cnt         <= '0;
            pid_full        <= 1'b0;
            bit_cnt         <= '0;
            bus.pkt_is_data <= 1'b0;
            bus.crc_err     <= 1'b0;
            bus.len_err     <= 1'b0;
            bus.pid_err     <= 1'b0;
          end
        end
        S_PID: begin
          if (bus.shift_enable) begin
            pid     <= pid_next;
            pid_cnt <= pid_cnt + 3'd1;
          end
          // A bit arriving with eop completes the PID before eop is handled
          if (bus.shift_enable && (pid_cnt == 3'd7)) begin
            pid_full <= 1'b1;
            if (pid_next[1:0] == 2'b11) state <= bus.eop ? S_FLUSH : S_DATA;
            else                        state <= bus.eop ? S_EVAL  : S_SKIP;
          end else if (bus.eop) begin
            state <= S_EVAL;
          end
          if (abort) state <= S_IDLE;
        end
        S_DATA: begin
          if (bus.shift_enable && !abort) begin
            if (bit_cnt != CNT_W'(SAT_BITS)) bit_cnt <= bit_cnt + CNT_W'(1);
            bus.crc_shift_en  <= 1'b1;
            bus.crc_serial_in <= bus.d_orig;
          end
          if (bus.eop)        state <= S_FLUSH;
          else if (abort)     state <= S_IDLE;
        end
        S_SKIP: begin
          if (bus.eop)        state <= S_EVAL;
          else if (abort)     state <= S_IDLE;
        end
        S_FLUSH: state <= S_EVAL;
        S_EVAL: begin
          state           <= S_IDLE;
          bus.pkt_done    <= 1'b1;
          bus.pkt_is_data <= data_pkt;
          bus.crc_err     <= data_pkt && !bus.crc_pass;
          bus.len_err     <= data_pkt && len_bad;
          bus.pid_err     <= pid_bad;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RX_CRC_ERRCNT_EN
  // Saturating CRC error counter; clear wins over increment
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_err_cnt <= '0;
    end else if (errcnt_clr) begin
      crc_err_cnt <= '0;
    end else if ((state == S_EVAL) && data_pkt && !bus.crc_pass &&
                 (crc_err_cnt != 8'hFF)) begin
      crc_err_cnt <= crc_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_crc_ctrl.sv
// Directed bench for usb_rx_crc_ctrl with a behavioural CRC-16 checker and a
// status scoreboard popped on every pkt_done.
module tb_usb_rx_crc_ctrl;

  localparam int unsigned MAXP = 64;

  typedef struct packed {
    logic is_data;
    logic crc;
    logic len;
    logic pid;
  } exp_t;

  logic clk;
  logic n_rst;
  usb_rx_crc_ctrl_if bus ();
`ifdef RX_CRC_ERRCNT_EN
  logic       errcnt_clr;
  logic [7:0] crc_err_cnt;
`endif

  usb_rx_crc_ctrl #(.MAX_PAYLOAD(MAXP)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
`ifdef RX_CRC_ERRCNT_EN
    ,
    .errcnt_clr  (errcnt_clr),
    .crc_err_cnt (crc_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    tx[$];
  exp_t  sb[$];
  logic [15:0] chk_reg;
  logic [15:0] good_res;

  function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
    logic fb;
    fb = r[15] ^ b;
    return fb ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
  endfunction

  // Serial checker model driven by the DUT's checker controls
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)                chk_reg <= 16'hFFFF;
    else if (bus.crc_clear)    chk_reg <= 16'hFFFF;
    else if (bus.crc_shift_en) chk_reg <= crc_step(chk_reg, bus.crc_serial_in);
  end
  assign bus.crc_pass = (chk_reg == good_res);

  function automatic logic [3:0] status();
    return {bus.pkt_is_data, bus.crc_err, bus.len_err, bus.pid_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every pkt_done must match the oldest expected status
  always @(negedge clk) begin
    if (n_rst && bus.pkt_done) begin
      if (sb.size() == 0) begin
        check("unexpected_pkt_done", 32'(1), 32'(0));
      end else begin
        check("status_at_done", 32'(status()), 32'(sb.pop_front()));
      end
    end
  end

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx.push_back(b[i]);
  endtask

  task automatic run_packet(input string name, input bit eop_last, input bit abort);
    int          n;
    int          nb;
    int          lat;
    logic [7:0]  pid;
    logic [15:0] r;
    bit          pid_ok;
    bit          is_data;
    bit          exp_sh;
    exp_t        e;
    n      = tx.size();
    pid    = '0;
    pid_ok = (n >= 8);
    for (int i = 0; i < 8 && i < n; i++) pid[i] = tx[i];
    is_data = pid_ok && (pid[1:0] == 2'b11);
    nb      = is_data ? n - 8 : 0;
    r       = 16'hFFFF;
    for (int i = 8; i < n; i++) r = crc_step(r, tx[i]);
    e.is_data = is_data;
    e.pid     = !pid_ok || (pid[7:4] != ~pid[3:0]);
    e.len     = is_data && ((nb % 8) != 0 || nb < 16 || nb > int'((MAXP + 2) * 8));
    e.crc     = is_data && (r != good_res);

    @(posedge clk); #1 bus.rcving = 1'b1;
    @(posedge clk); #1;
    check({name, ":status_cleared"}, 32'(status()), 32'(0));
    for (int i = 0; i < n; i++) begin
      bus.shift_enable = 1'b1;
      bus.d_orig       = tx[i];
      bus.eop          = eop_last && !abort && (i == n - 1);
      if (bus.eop) sb.push_back(e);
      @(posedge clk); #1;
      bus.shift_enable = 1'b0;
      bus.eop          = 1'b0;
      exp_sh = is_data && (i >= 8);
      check({name, ":shift_en"}, 32'(bus.crc_shift_en), 32'(exp_sh));
      if (exp_sh) check({name, ":serial_in"}, 32'(bus.crc_serial_in), 32'(tx[i]));
    end
    if (abort) begin
      bus.rcving = 1'b0;
      @(posedge clk); #1;
      check({name, ":abort_idle"}, 32'(bus.crc_clear), 32'(1));
      repeat (4) @(posedge clk);
      #1 check({name, ":abort_no_done"}, 32'(bus.pkt_done), 32'(0));
      check({name, ":abort_status"}, 32'(status()), 32'(0));
      tx.delete();
      return;
    end
    if (!eop_last) begin
      bus.eop = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1 bus.eop = 1'b0;
    end
    bus.rcving = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.pkt_done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, ":done_latency"}, 32'(lat), 32'(is_data ? 3 : 2));
    @(posedge clk); #1;
    check({name, ":done_strobe"}, 32'(bus.pkt_done), 32'(0));
    repeat (2) @(posedge clk);
    #1 check({name, ":status_hold"}, 32'(status()), 32'(e));
    tx.delete();
  endtask

  initial begin
    logic [15:0] r;
    n_rst            = 1'b0;
    bus.rcving       = 1'b0;
    bus.shift_enable = 1'b0;
    bus.d_orig       = 1'b0;
    bus.eop          = 1'b0;
`ifdef RX_CRC_ERRCNT_EN
    errcnt_clr = 1'b0;
`endif
    // Residual left by a valid zero-length DATA packet (CRC bytes 00 00)
    r = 16'hFFFF;
    for (int i = 0; i < 16; i++) r = crc_step(r, 1'b0);
    good_res = r;

    #12;
    check("rst:crc_clear", 32'(bus.crc_clear), 32'(1));
    check("rst:shift_en", 32'(bus.crc_shift_en), 32'(0));
    check("rst:pkt_done", 32'(bus.pkt_done), 32'(0));
    check("rst:status", 32'(status()), 32'(0));
    @(negedge clk) n_rst = 1'b1;

    add_byte(8'hC3); add_byte(8'h00); add_byte(8'h00);
    run_packet("data_zlp", 1'b0, 1'b0);

    add_byte(8'hC3); add_byte(8'h00); add_byte(8'h01);
    run_packet("data_badcrc", 1'b1, 1'b0);

    // Reset while idle with crc_err held
    @(posedge clk); #3 n_rst = 1'b0;
    #1;
    check("rst_idle:status", 32'(status()), 32'(0));
    check("rst_idle:crc_clear", 32'(bus.crc_clear), 32'(1));
    @(negedge clk) n_rst = 1'b1;

    add_byte(8'hC3); add_byte(8'hA5); add_byte(8'h5A);
    run_packet("abort", 1'b0, 1'b1);

    add_byte(8'h69); add_byte(8'h12);
    run_packet("token_in", 1'b0, 1'b0);

    add_byte(8'h4B); add_byte(8'hFF);
    for (int i = 0; i < 4; i++) tx.push_back(1'b1);
    run_packet("len_12", 1'b0, 1'b0);

    add_byte(8'hC2); add_byte(8'h00);
    run_packet("pid_bad", 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) tx.push_back(1'b1);
    run_packet("pid_short", 1'b0, 1'b0);

    add_byte(8'hC3); add_byte(8'h7E);
    run_packet("len_1byte", 1'b1, 1'b0);

    add_byte(8'h4B);
    for (int i = 0; i < int'(MAXP) + 2; i++) add_byte(8'($urandom_range(0, 255)));
    run_packet("len_max", 1'b0, 1'b0);

    add_byte(8'hC3);
    for (int i = 0; i < int'(MAXP) + 3; i++) add_byte(8'($urandom_range(0, 255)));
    run_packet("len_over", 1'b0, 1'b0);

    // Reset asserted mid-DATA right after a shift strobe
    add_byte(8'hC3); tx.push_back(1'b1);
    @(posedge clk); #1 bus.rcving = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      bus.shift_enable = 1'b1;
      bus.d_orig       = tx[i];
      @(posedge clk); #1 bus.shift_enable = 1'b0;
    end
    tx.delete();
    check("rst_data:pre_shift", 32'(bus.crc_shift_en), 32'(1));
    #2 n_rst = 1'b0;
    #1;
    check("rst_data:crc_clear", 32'(bus.crc_clear), 32'(1));
    check("rst_data:shift_en", 32'(bus.crc_shift_en), 32'(0));
    check("rst_data:pkt_done", 32'(bus.pkt_done), 32'(0));
    check("rst_data:status", 32'(status()), 32'(0));
    bus.rcving = 1'b0;
    @(negedge clk) n_rst = 1'b1;

    add_byte(8'hC3); add_byte(8'h00); add_byte(8'h00);
    run_packet("data_zlp2", 1'b1, 1'b0);

`ifdef RX_CRC_ERRCNT_EN
    @(posedge clk); #1 errcnt_clr = 1'b1;
    @(posedge clk); #1 errcnt_clr = 1'b0;
    check("errcnt:clr0", 32'(crc_err_cnt), 32'(0));
    for (int p = 0; p < 3; p++) begin
      add_byte(8'hC3); add_byte(8'h00); add_byte(8'h01);
      run_packet("errcnt_pkt", 1'b0, 1'b0);
    end
    check("errcnt:three", 32'(crc_err_cnt), 32'(3));
    @(posedge clk); #1 errcnt_clr = 1'b1;
    @(posedge clk); #1 errcnt_clr = 1'b0;
    check("errcnt:clr", 32'(crc_err_cnt), 32'(0));
`endif

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
